// File: rtl/piso_pkg.sv
// piso_pkg: shared definitions for the parallel-in/serial-out transmitter.
//   state_t : FSM state encoding (IDLE, SHIFT)
//   cnt_w() : bit-counter width for a given word width
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width needed to hold a count of WIDTH-1 down to 0.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_hold.sv
// piso_hold: one-entry valid/ready holding register in front of the shifter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   pi_data     : parallel word offered by the producer
//   pi_valid    : pi_data is valid
//   pi_ready    : register empty; word accepted when pi_valid && pi_ready
//   load        : shifter takes the held word this edge (empties the register)
//   hold_data   : held word
//   hold_full   : register holds a word
module piso_hold
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pi_data,
  input  logic             pi_valid,
  output logic             pi_ready,
  input  logic             load,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full
);

  logic accept;

  // pi_ready comes straight from the full flag, so the producer never sees a
  // combinational path back from its own pi_valid.
  assign pi_ready = !hold_full;
  assign accept   = pi_valid && !hold_full;

  // load only happens while full and accept only while empty, so the two can
  // never collide in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (load) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end
      if (accept) begin
        hold_data <= pi_data;
      end
    end
  end

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter, MSB first, feeding a
// left-shifting SIPO. One word is buffered in piso_hold while the shifter
// drains the previous one, so words stream with no idle bubble.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   pi_data    : parallel word (WIDTH bits)
//   pi_valid   : pi_data valid
//   pi_ready   : holding register empty
//   so         : serial bit, MSB first
//   so_valid   : so carries a valid bit
//   so_ready   : consumer takes so at this edge
//   so_last    : current bit is bit 0 of its word
//   busy       : shifter active or holding register full
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pi_data,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so,
  output logic             so_valid,
  input  logic             so_ready,
  output logic             so_last,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             last_bit;
  logic             load;

  assign last_bit = (bit_cnt == '0);

  // The held word moves into the shifter either from IDLE or right as the
  // final bit of the current word is consumed (back-to-back streaming).
  assign load = hold_full &&
                ((state == IDLE) || (so_ready && last_bit));

  piso_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .pi_data   (pi_data),
    .pi_valid  (pi_valid),
    .pi_ready  (pi_ready),
    .load      (load),
    .hold_data (hold_data),
    .hold_full (hold_full)
  );

  // Shifter FSM. With so_ready low nothing changes, so so/so_last stay
  // stable while so_valid is held. The counter is only reloaded at a load and
  // only decremented while non-zero, so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sh      <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hold_full) begin
            sh      <= hold_data;
            bit_cnt <= CNT_LOAD;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (so_ready) begin
            if (!last_bit) begin
              sh      <= {sh[WIDTH-2:0], 1'b0};
              bit_cnt <= bit_cnt - CNT_W'(1);
            end else if (hold_full) begin
              sh      <= hold_data;
              bit_cnt <= CNT_LOAD;
            end else begin
              sh      <= '0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          sh      <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs are decoded from registers only; nothing passes from an input.
  assign so_valid = (state == SHIFT);
  assign so       = so_valid & sh[WIDTH-1];
  assign so_last  = so_valid & last_bit;
  assign busy     = so_valid | hold_full;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: self-checking bench for piso_tx. A monitor in tick() records
// input handshakes and output beats; the reference model turns accepted words
// into their MSB-first bit stream and each scenario task compares against it.
module tb_piso_tx;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] pi_data;
  logic         pi_valid;
  logic         pi_ready;
  logic         so;
  logic         so_valid;
  logic         so_ready;
  logic         so_last;
  logic         busy;

  int total;
  int bad;
  int cyc;

  logic [W-1:0] acc_q[$];
  int           acc_cyc[$];
  logic         got_b[$];
  logic         got_l[$];
  logic         exp_b[$];
  logic         exp_l[$];
  logic         tr_v[$];
  logic         tr_pir[$];
  logic         tr_busy[$];

  piso_tx #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pi_data  (pi_data),
    .pi_valid (pi_valid),
    .pi_ready (pi_ready),
    .so       (so),
    .so_valid (so_valid),
    .so_ready (so_ready),
    .so_last  (so_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record the current cycle (sampled at the falling edge), then advance to
  // the next falling edge.
  task automatic tick();
    tr_v.push_back(so_valid);
    tr_pir.push_back(pi_ready);
    tr_busy.push_back(busy);
    if (rst_n && pi_valid && pi_ready) begin
      acc_q.push_back(pi_data);
      acc_cyc.push_back(cyc);
    end
    if (rst_n && so_valid && so_ready) begin
      got_b.push_back(so);
      got_l.push_back(so_last);
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_trace();
    acc_q.delete(); acc_cyc.delete();
    got_b.delete(); got_l.delete();
    exp_b.delete(); exp_l.delete();
    tr_v.delete(); tr_pir.delete(); tr_busy.delete();
    cyc = 0;
  endtask

  // Reference model: a word is sent as bits W-1 down to 0, last flag on bit 0.
  task automatic make_exp(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      exp_b.push_back(((w >> i) & 1) != 0);
      exp_l.push_back(i == 0);
    end
  endtask

  task automatic drain(output bit timed_out);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    tick();
    timed_out = (n >= 200);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0; pi_valid = 1'b0; pi_data = '0; so_ready = 1'b0;
    tick(); tick();
    total++; if (pi_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_pi_ready: got %b want 1", pi_ready); end
    total++; if (so_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_so_valid: got %b want 0", so_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    total++; if (so !== 1'b0 || so_last !== 1'b0) begin bad++; $display("[TB] FAIL rst_so: got so=%b last=%b want 0 0", so, so_last); end
    rst_n = 1'b1;
    tick();
    total++; if (pi_ready !== 1'b1 || so_valid !== 1'b0 || busy !== 1'b0 || so !== 1'b0) begin
      bad++; $display("[TB] FAIL idle_after_rst: got ready=%b valid=%b busy=%b so=%b want 1 0 0 0", pi_ready, so_valid, busy, so);
    end
  endtask

  task automatic test_single();
    logic [6:0]   ev;
    logic [W-1:0] po;
    $display("[TB] test_single");
    clear_trace();
    so_ready = 1'b1;
    pi_data = 4'b1101; pi_valid = 1'b1;
    tick();
    pi_valid = 1'b0; pi_data = '0;
    for (int i = 0; i < 6; i++) tick();
    // idx0: accept cycle, idx1: held, idx2..5: four bits, idx6: idle again
    ev = 7'b0111100;
    for (int i = 0; i < 7; i++) begin
      total++; if (tr_v[i] !== ev[i]) begin bad++; $display("[TB] FAIL single_valid[%0d]: got %b want %b", i, tr_v[i], ev[i]); end
    end
    total++; if (tr_busy[5] !== 1'b1 || tr_busy[6] !== 1'b0) begin
      bad++; $display("[TB] FAIL single_busy: got %b%b want 10", tr_busy[5], tr_busy[6]);
    end
    make_exp(4'b1101);
    total++; if (got_b.size() != exp_b.size()) begin bad++; $display("[TB] FAIL single_len: got %0d want %0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
      total++; if (got_b[i] !== exp_b[i] || got_l[i] !== exp_l[i]) begin
        bad++; $display("[TB] FAIL single_bit[%0d]: got so=%b last=%b want so=%b last=%b", i, got_b[i], got_l[i], exp_b[i], exp_l[i]);
      end
    end
    po = '0;
    foreach (got_b[i]) po = {po[W-2:0], got_b[i]};
    total++; if (po !== 4'b1101) begin bad++; $display("[TB] FAIL single_sipo: got %b want 1101", po); end
  endtask

  task automatic test_back_to_back();
    int n;
    int f;
    int run;
    bit to;
    $display("[TB] test_back_to_back");
    clear_trace();
    so_ready = 1'b1;
    pi_valid = 1'b1; pi_data = 4'b1010;
    n = 0;
    while (acc_q.size() < 2 && n < 20) begin
      tick();
      n++;
      if (acc_q.size() == 1) pi_data = 4'b0111;
    end
    pi_valid = 1'b0;
    drain(to);
    total++; if (to || acc_q.size() != 2) begin bad++; $display("[TB] FAIL b2b_accept: got %0d words timeout=%0d want 2", acc_q.size(), to); end
    if (acc_q.size() == 2) begin
      total++; if (tr_pir[acc_cyc[0] + 1] !== 1'b0 || tr_pir[acc_cyc[1] + 1] !== 1'b0) begin
        bad++; $display("[TB] FAIL b2b_ready_low: got %b %b want 0 0", tr_pir[acc_cyc[0] + 1], tr_pir[acc_cyc[1] + 1]);
      end
    end
    make_exp(4'b1010);
    make_exp(4'b0111);
    total++; if (got_b.size() != exp_b.size()) begin bad++; $display("[TB] FAIL b2b_len: got %0d want %0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
      total++; if (got_b[i] !== exp_b[i] || got_l[i] !== exp_l[i]) begin
        bad++; $display("[TB] FAIL b2b_bit[%0d]: got so=%b last=%b want so=%b last=%b", i, got_b[i], got_l[i], exp_b[i], exp_l[i]);
      end
    end
    f = -1;
    foreach (tr_v[i]) if (f < 0 && tr_v[i] === 1'b1) f = i;
    run = 0;
    if (f >= 0) while (f + run < tr_v.size() && tr_v[f + run] === 1'b1) run++;
    total++; if (run != 2 * W) begin bad++; $display("[TB] FAIL b2b_contiguous: got run of %0d valid cycles want %0d", run, 2 * W); end
  endtask

  task automatic test_backpressure();
    int n;
    bit to;
    $display("[TB] test_backpressure");
    clear_trace();
    so_ready = 1'b1;
    pi_valid = 1'b1; pi_data = 4'b1001;
    tick();
    pi_valid = 1'b0;
    n = 0;
    while (got_b.size() < 2 && n < 10) begin tick(); n++; end
    total++; if (got_b.size() != 2) begin bad++; $display("[TB] FAIL bp_first_bits: got %0d bits want 2", got_b.size()); end
    so_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (so_valid !== 1'b1 || so !== 1'b0 || so_last !== 1'b0) begin
        bad++; $display("[TB] FAIL bp_stall[%0d]: got valid=%b so=%b last=%b want 1 0 0", i, so_valid, so, so_last);
      end
      tick();
    end
    so_ready = 1'b1;
    drain(to);
    total++; if (to) begin bad++; $display("[TB] FAIL bp_drain: got timeout want idle"); end
    make_exp(4'b1001);
    total++; if (got_b.size() != exp_b.size()) begin bad++; $display("[TB] FAIL bp_len: got %0d want %0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
      total++; if (got_b[i] !== exp_b[i] || got_l[i] !== exp_l[i]) begin
        bad++; $display("[TB] FAIL bp_bit[%0d]: got so=%b last=%b want so=%b last=%b", i, got_b[i], got_l[i], exp_b[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int nv;
    bit to;
    $display("[TB] test_reset_mid");
    clear_trace();
    so_ready = 1'b1;
    pi_valid = 1'b1; pi_data = 4'b1111;
    n = 0;
    while (acc_q.size() < 2 && n < 20) begin
      tick();
      n++;
      if (acc_q.size() == 1) pi_data = 4'b0001;
    end
    pi_valid = 1'b0;
    n = 0;
    while (got_b.size() < 2 && n < 10) begin tick(); n++; end
    total++; if (got_b.size() != 2 || pi_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_setup: got bits=%0d ready=%b want 2 0", got_b.size(), pi_ready);
    end
    rst_n = 1'b0;
    #1;
    total++; if (pi_ready !== 1'b1 || so_valid !== 1'b0 || so !== 1'b0 || so_last !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_async_rst: got ready=%b valid=%b so=%b last=%b busy=%b want 1 0 0 0 0", pi_ready, so_valid, so, so_last, busy);
    end
    tick(); tick();
    rst_n = 1'b1;
    clear_trace();
    for (int i = 0; i < 8; i++) tick();
    nv = 0;
    foreach (tr_v[i]) if (tr_v[i] !== 1'b0) nv++;
    total++; if (nv != 0 || got_b.size() != 0) begin bad++; $display("[TB] FAIL mid_residual: got %0d valid cycles want 0", nv); end
    pi_valid = 1'b1; pi_data = 4'b0110;
    tick();
    pi_valid = 1'b0;
    drain(to);
    make_exp(4'b0110);
    total++; if (to || got_b.size() != exp_b.size()) begin bad++; $display("[TB] FAIL mid_len: got %0d want %0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
      total++; if (got_b[i] !== exp_b[i] || got_l[i] !== exp_l[i]) begin
        bad++; $display("[TB] FAIL mid_bit[%0d]: got so=%b last=%b want so=%b last=%b", i, got_b[i], got_l[i], exp_b[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_hold_full();
    int n;
    bit to;
    $display("[TB] test_hold_full");
    clear_trace();
    so_ready = 1'b1;
    pi_valid = 1'b1; pi_data = 4'b1100;
    n = 0;
    while (acc_q.size() < 2 && n < 20) begin
      tick();
      n++;
      if (acc_q.size() == 1) pi_data = 4'b0101;
    end
    // Shifter busy with the first word and hold full with the second: keep
    // offering junk, none of it may be taken.
    for (int i = 0; i < 3; i++) begin
      pi_data = W'($urandom);
      total++; if (pi_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_ready[%0d]: got %b want 0", i, pi_ready); end
      tick();
    end
    pi_valid = 1'b0;
    drain(to);
    total++; if (to || acc_q.size() != 2) begin bad++; $display("[TB] FAIL hold_accepts: got %0d want 2", acc_q.size()); end
    make_exp(4'b1100);
    make_exp(4'b0101);
    total++; if (got_b.size() != exp_b.size()) begin bad++; $display("[TB] FAIL hold_len: got %0d want %0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
      total++; if (got_b[i] !== exp_b[i] || got_l[i] !== exp_l[i]) begin
        bad++; $display("[TB] FAIL hold_bit[%0d]: got so=%b last=%b want so=%b last=%b", i, got_b[i], got_l[i], exp_b[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_random();
    localparam int NW = 40;
    int   n;
    logic prev_stall;
    logic prev_so;
    logic prev_last;
    bit   to;
    $display("[TB] test_random");
    clear_trace();
    prev_stall = 1'b0; prev_so = 1'b0; prev_last = 1'b0;
    n = 0;
    while ((acc_q.size() < NW || busy) && n < 3000) begin
      if (prev_stall) begin
        total++; if (so_valid !== 1'b1 || so !== prev_so || so_last !== prev_last) begin
          bad++; $display("[TB] FAIL rnd_stall cyc %0d: got valid=%b so=%b last=%b want 1 %b %b", cyc, so_valid, so, so_last, prev_so, prev_last);
        end
      end
      pi_valid = (acc_q.size() < NW) && ($urandom_range(0, 3) != 0);
      pi_data  = W'($urandom);
      so_ready = ($urandom_range(0, 3) != 0);
      prev_stall = so_valid && !so_ready;
      prev_so    = so;
      prev_last  = so_last;
      tick();
      n++;
    end
    pi_valid = 1'b0;
    so_ready = 1'b1;
    drain(to);
    total++; if (n >= 3000 || to || acc_q.size() != NW) begin bad++; $display("[TB] FAIL rnd_progress: got %0d words in %0d cycles want %0d", acc_q.size(), n, NW); end
    foreach (acc_q[i]) make_exp(acc_q[i]);
    total++; if (got_b.size() != exp_b.size()) begin bad++; $display("[TB] FAIL rnd_len: got %0d want %0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
      total++; if (got_b[i] !== exp_b[i] || got_l[i] !== exp_l[i]) begin
        bad++; $display("[TB] FAIL rnd_bit[%0d]: got so=%b last=%b want so=%b last=%b", i, got_b[i], got_l[i], exp_b[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; pi_valid = 1'b0; pi_data = '0; so_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_hold_full();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
